muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
- Execute-stage sequencer for the MIPS multiply/divide resource.
- Drives the AXI-stream handshakes of the signed and unsigned divider IPs and stalls the stage until the quotient/remainder arrive.
- Produces exactly one HI/LO write per mult/multu/div/divu/mthi/mtlo instruction, at the cycle the instruction leaves EXE.
- Sits beside the ALU in exe_stage; its ready_go output feeds es_ready_go.

Parameters:
- CNT_W, 6, width of the divide-latency performance counter (saturating).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- es_valid  input  1  EXE stage holds a valid instruction
- ms_allowin  input  1  MEM stage accepts this cycle
- op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo  input  1 each  decoded op of the EXE instruction; at most one set
- src1  input  32  rs value
- src2  input  32  rt value
- ready_go  output  1  EXE may hand off this cycle
- div_dividend_tdata  output  32  = src1
- div_divisor_tdata  output  32  = src2
- sdiv_dividend_tvalid, sdiv_divisor_tvalid  output  1 each  signed divider input valids
- sdiv_dividend_tready, sdiv_divisor_tready  input  1 each
- sdiv_dout_tvalid  input  1
- sdiv_dout_tdata  input  64  {quotient, remainder}
- udiv_dividend_tvalid, udiv_divisor_tvalid  output  1 each  unsigned divider input valids
- udiv_dividend_tready, udiv_divisor_tready  input  1 each
- udiv_dout_tvalid  input  1
- udiv_dout_tdata  input  64  {quotient, remainder}
- hi_we, lo_we  output  1 each  HI/LO write enables
- hi_wdata, lo_wdata  output  32 each
- busy  output  1  divide in flight (state != IDLE)
- div_cycles  output  CNT_W  cycles spent in the last/current divide

Behaviour:
- Reset values: state = IDLE; all tvalids 0; result register 0; div_cycles 0; busy 0.
- Divider IPs are not reset by this block.
- States and transitions:
  - IDLE -> SEND when es_valid && (op_div || op_divu). On that edge, both tvalids of the selected divider go high (registered; first valid one cycle after es_valid).
  - SEND: each tvalid stays high until its own handshake (tvalid && tready), then drops the next cycle. The two handshakes may complete in any order or the same cycle. -> WAIT once both have completed.
  - WAIT: on the selected divider's dout_tvalid, capture dout_tdata into the 64-bit result register. -> DONE.
  - DONE: ready_go = 1. On ms_allowin -> IDLE. Hold DONE otherwise, with no reissue.
- ready_go:
  - 0 for div/divu unless in DONE.
  - 1 for all other ops, including non-div instructions while in IDLE.
- commit = es_valid && ready_go && ms_allowin.
- HI/LO writes, on commit only:
  - mult: signed src1*src2. LO = product[31:0], HI = product[63:32].
  - multu: the same, unsigned.
  - div/divu: LO = result[63:32] (quotient), HI = result[31:0] (remainder).
  - mthi: HI = src1. mtlo: LO = src1.
  - hi_we and lo_we are 0 on every non-commit cycle, including a stalled EXE.
- dout_tvalid from the non-selected divider, or outside WAIT, is ignored.
- Divide by zero: no trap; the IP output is passed through unchanged.
- div_cycles: cleared to 0 on the IDLE->SEND edge, +1 each cycle in SEND or WAIT, saturates at 2^CNT_W-1, holds in DONE/IDLE.
- Reset asserted mid-divide: immediately IDLE, tvalids low, no HI/LO write. A late dout_tvalid after reset is ignored in IDLE.
- es_valid dropping while busy is not legal; the stage is stalled by ready_go.

Test Plan:
- mult, src1=0xFFFFFFFE (-2), src2=3, ms_allowin=1 -> same cycle ready_go=1, hi_we=lo_we=1, LO=0xFFFFFFFA, HI=0xFFFFFFFF. multu same operands -> LO=0xFFFFFFFA, HI=0x00000002.
- div 7/-2, signed IP tready=1, dout after 20 cycles = {0xFFFFFFFD, 0x00000001} -> sdiv tvalids high exactly 1 cycle, ready_go=0 until DONE, then LO=0xFFFFFFFD, HI=1, one write only; div_cycles ≈ 21.
- divu with dividend tready delayed 3 cycles and divisor tready immediate -> divisor tvalid drops after 1 cycle, dividend tvalid held 4 cycles, WAIT entered after the later handshake.
- div result ready but ms_allowin=0 for 5 cycles -> DONE held, hi_we=lo_we=0 throughout, single write on the cycle ms_allowin=1, no second tvalid issued.
- mthi src1=0x12345678 with ms_allowin=0, then 1 -> no write while stalled, then hi_we=1 with 0x12345678, lo_we=0.
- Reset pulsed in WAIT, then stray udiv_dout_tvalid -> state IDLE, busy=0, no HI/LO write, div_cycles=0.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
//
// Execute-stage sequencer for the MIPS multiply/divide resource. Sits beside
// the ALU in exe_stage.
//
// Multiplies and mthi/mtlo complete in the same cycle. Divides are handed to an
// external signed or unsigned divider IP over AXI-stream. The stage is stalled
// through ready_go until the quotient/remainder come back. Exactly one HI/LO
// write is produced per instruction, on the cycle it leaves EXE.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   es_valid, ms_allowin       EXE holds a valid instruction / MEM accepts
//   op_*                       decoded op of the EXE instruction (at most one)
//   src1, src2                 rs / rt values
//   ready_go                   EXE may hand off this cycle (feeds es_ready_go)
//   div_*_tdata                operands to both divider IPs
//   sdiv_* / udiv_*            AXI-stream handshakes of signed/unsigned IPs
//   hi_we, lo_we, hi/lo_wdata  HI/LO register write port
//   busy                       divide in flight
//   div_cycles                 saturating cycle count of last/current divide
// -----------------------------------------------------------------------------
module muldiv_ctrl #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             es_valid,
    input  logic             ms_allowin,
    input  logic             op_mult,
    input  logic             op_multu,
    input  logic             op_div,
    input  logic             op_divu,
    input  logic             op_mthi,
    input  logic             op_mtlo,
    input  logic [31:0]      src1,
    input  logic [31:0]      src2,

    output logic             ready_go,

    output logic [31:0]      div_dividend_tdata,
    output logic [31:0]      div_divisor_tdata,

    output logic             sdiv_dividend_tvalid,
    output logic             sdiv_divisor_tvalid,
    input  logic             sdiv_dividend_tready,
    input  logic             sdiv_divisor_tready,
    input  logic             sdiv_dout_tvalid,
    input  logic [63:0]      sdiv_dout_tdata,

    output logic             udiv_dividend_tvalid,
    output logic             udiv_divisor_tvalid,
    input  logic             udiv_dividend_tready,
    input  logic             udiv_divisor_tready,
    input  logic             udiv_dout_tvalid,
    input  logic [63:0]      udiv_dout_tdata,

    output logic             hi_we,
    output logic             lo_we,
    output logic [31:0]      hi_wdata,
    output logic [31:0]      lo_wdata,

    output logic             busy,
    output logic [CNT_W-1:0] div_cycles
);

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StWait,
        StDone
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e           state_q, state_d;
    logic             sel_signed_q, sel_signed_d;  // 1: signed IP selected
    logic             dvd_vld_q, dvd_vld_d;        // dividend tvalid
    logic             dvs_vld_q, dvs_vld_d;        // divisor tvalid
    logic [63:0]      result_q, result_d;          // {quotient, remainder}
    logic [CNT_W-1:0] div_cycles_q, div_cycles_d;

    logic             is_div;
    logic             dvd_tready;
    logic             dvs_tready;
    logic             dvd_hs;
    logic             dvs_hs;
    logic             dout_vld;
    logic [63:0]      dout_data;
    logic             commit;
    logic [63:0]      prod_s;
    logic [63:0]      prod_u;

    // -------------------------------------------------------------------------
    // Selected-divider view
    // -------------------------------------------------------------------------
    assign is_div     = op_div | op_divu;
    assign dvd_tready = sel_signed_q ? sdiv_dividend_tready : udiv_dividend_tready;
    assign dvs_tready = sel_signed_q ? sdiv_divisor_tready  : udiv_divisor_tready;
    assign dout_vld   = sel_signed_q ? sdiv_dout_tvalid     : udiv_dout_tvalid;
    assign dout_data  = sel_signed_q ? sdiv_dout_tdata      : udiv_dout_tdata;

    assign dvd_hs = dvd_vld_q & dvd_tready;
    assign dvs_hs = dvs_vld_q & dvs_tready;

    assign div_dividend_tdata = src1;
    assign div_divisor_tdata  = src2;

    assign sdiv_dividend_tvalid = dvd_vld_q &  sel_signed_q;
    assign sdiv_divisor_tvalid  = dvs_vld_q &  sel_signed_q;
    assign udiv_dividend_tvalid = dvd_vld_q & ~sel_signed_q;
    assign udiv_divisor_tvalid  = dvs_vld_q & ~sel_signed_q;

    assign busy       = (state_q != StIdle);
    assign div_cycles = div_cycles_q;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        sel_signed_d = sel_signed_q;
        dvd_vld_d    = dvd_vld_q;
        dvs_vld_d    = dvs_vld_q;
        result_d     = result_q;
        div_cycles_d = div_cycles_q;

        unique case (state_q)
            StIdle: begin
                if (es_valid && is_div) begin
                    state_d      = StSend;
                    sel_signed_d = op_div;
                    dvd_vld_d    = 1'b1;
                    dvs_vld_d    = 1'b1;
                    div_cycles_d = '0;
                end
            end

            StSend: begin
                if (div_cycles_q != CntMax) begin
                    div_cycles_d = div_cycles_q + 1'b1;
                end
                if (dvd_hs) begin
                    dvd_vld_d = 1'b0;
                end
                if (dvs_hs) begin
                    dvs_vld_d = 1'b0;
                end
                // Handshakes may land in either order or together; leave once
                // each channel is either already done or completing now.
                if ((!dvd_vld_q || dvd_hs) && (!dvs_vld_q || dvs_hs)) begin
                    state_d = StWait;
                end
            end

            StWait: begin
                if (div_cycles_q != CntMax) begin
                    div_cycles_d = div_cycles_q + 1'b1;
                end
                if (dout_vld) begin
                    result_d = dout_data;
                    state_d  = StDone;
                end
            end

            StDone: begin
                if (ms_allowin) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            sel_signed_q <= 1'b0;
            dvd_vld_q    <= 1'b0;
            dvs_vld_q    <= 1'b0;
            result_q     <= '0;
            div_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            sel_signed_q <= sel_signed_d;
            dvd_vld_q    <= dvd_vld_d;
            dvs_vld_q    <= dvs_vld_d;
            result_q     <= result_d;
            div_cycles_q <= div_cycles_d;
        end
    end

    // -------------------------------------------------------------------------
    // Handoff and HI/LO write port
    // -------------------------------------------------------------------------
    // Both products via a 64-bit unsigned multiply; sign-extending the operands
    // first gives the correct two's-complement low 64 bits for mult.
    assign prod_s = {{32{src1[31]}}, src1} * {{32{src2[31]}}, src2};
    assign prod_u = {32'h0, src1} * {32'h0, src2};

    assign ready_go = is_div ? (state_q == StDone) : 1'b1;
    assign commit   = es_valid & ready_go & ms_allowin;

    always_comb begin
        hi_we    = 1'b0;
        lo_we    = 1'b0;
        hi_wdata = '0;
        lo_wdata = '0;

        if (commit) begin
            unique case (1'b1)
                op_mult: begin
                    hi_we    = 1'b1;
                    lo_we    = 1'b1;
                    hi_wdata = prod_s[63:32];
                    lo_wdata = prod_s[31:0];
                end
                op_multu: begin
                    hi_we    = 1'b1;
                    lo_we    = 1'b1;
                    hi_wdata = prod_u[63:32];
                    lo_wdata = prod_u[31:0];
                end
                op_div, op_divu: begin
                    // Quotient to LO, remainder to HI; divide-by-zero passes
                    // through whatever the IP returned.
                    hi_we    = 1'b1;
                    lo_we    = 1'b1;
                    hi_wdata = result_q[31:0];
                    lo_wdata = result_q[63:32];
                end
                op_mthi: begin
                    hi_we    = 1'b1;
                    hi_wdata = src1;
                end
                op_mtlo: begin
                    lo_we    = 1'b1;
                    lo_wdata = src1;
                end
                default: begin
                    hi_we = 1'b0;
                    lo_we = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl. Expected HI/LO writes are queued when an
// instruction is driven and compared whenever the DUT raises hi_we/lo_we.
module tb_muldiv_ctrl;

    localparam int unsigned CNT_W = 6;

    logic             clk = 1'b0;
    logic             reset;
    logic             es_valid, ms_allowin;
    logic             op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo;
    logic [31:0]      src1, src2;
    logic             ready_go;
    logic [31:0]      div_dividend_tdata, div_divisor_tdata;
    logic             sdiv_dividend_tvalid, sdiv_divisor_tvalid;
    logic             sdiv_dividend_tready, sdiv_divisor_tready;
    logic             sdiv_dout_tvalid;
    logic [63:0]      sdiv_dout_tdata;
    logic             udiv_dividend_tvalid, udiv_divisor_tvalid;
    logic             udiv_dividend_tready, udiv_divisor_tready;
    logic             udiv_dout_tvalid;
    logic [63:0]      udiv_dout_tdata;
    logic             hi_we, lo_we;
    logic [31:0]      hi_wdata, lo_wdata;
    logic             busy;
    logic [CNT_W-1:0] div_cycles;

    muldiv_ctrl #(.CNT_W(CNT_W)) dut (
        .clk                  (clk),
        .reset                (reset),
        .es_valid             (es_valid),
        .ms_allowin           (ms_allowin),
        .op_mult              (op_mult),
        .op_multu             (op_multu),
        .op_div               (op_div),
        .op_divu              (op_divu),
        .op_mthi              (op_mthi),
        .op_mtlo              (op_mtlo),
        .src1                 (src1),
        .src2                 (src2),
        .ready_go             (ready_go),
        .div_dividend_tdata   (div_dividend_tdata),
        .div_divisor_tdata    (div_divisor_tdata),
        .sdiv_dividend_tvalid (sdiv_dividend_tvalid),
        .sdiv_divisor_tvalid  (sdiv_divisor_tvalid),
        .sdiv_dividend_tready (sdiv_dividend_tready),
        .sdiv_divisor_tready  (sdiv_divisor_tready),
        .sdiv_dout_tvalid     (sdiv_dout_tvalid),
        .sdiv_dout_tdata      (sdiv_dout_tdata),
        .udiv_dividend_tvalid (udiv_dividend_tvalid),
        .udiv_divisor_tvalid  (udiv_divisor_tvalid),
        .udiv_dividend_tready (udiv_dividend_tready),
        .udiv_divisor_tready  (udiv_divisor_tready),
        .udiv_dout_tvalid     (udiv_dout_tvalid),
        .udiv_dout_tdata      (udiv_dout_tdata),
        .hi_we                (hi_we),
        .lo_we                (lo_we),
        .hi_wdata             (hi_wdata),
        .lo_wdata             (lo_wdata),
        .busy                 (busy),
        .div_cycles           (div_cycles)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [65:0] sb_q[$];  // {hi_we, lo_we, hi, lo}

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic hw, input logic lw, input logic [31:0] h,
                        input logic [31:0] l);
        sb_q.push_back({hw, lw, h, l});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Every write the DUT makes must match the oldest queued expectation.
    always @(negedge clk) begin
        logic [65:0] obs_w;
        logic [65:0] exp_w;
        if (hi_we || lo_we) begin
            obs_w = {hi_we, lo_we, hi_we ? hi_wdata : 32'h0, lo_we ? lo_wdata : 32'h0};
            exp_w = (sb_q.size() != 0) ? sb_q.pop_front() : 66'h0;
            chk("hilo_write", obs_w, exp_w);
        end
    end

    longint          sa, sb, sp;
    longint unsigned ua, ub, up;

    initial begin
        reset = 1'b1; es_valid = 1'b0; ms_allowin = 1'b1;
        op_mult = 1'b0; op_multu = 1'b0; op_div = 1'b0;
        op_divu = 1'b0; op_mthi = 1'b0; op_mtlo = 1'b0;
        src1 = '0; src2 = '0;
        sdiv_dividend_tready = 1'b0; sdiv_divisor_tready = 1'b0;
        udiv_dividend_tready = 1'b0; udiv_divisor_tready = 1'b0;
        sdiv_dout_tvalid = 1'b0; sdiv_dout_tdata = '0;
        udiv_dout_tvalid = 1'b0; udiv_dout_tdata = '0;

        // Reset state
        sample();
        chk("rst_busy", 66'(busy), 66'd0);
        chk("rst_tvalids", 66'({sdiv_dividend_tvalid, sdiv_divisor_tvalid,
                                udiv_dividend_tvalid, udiv_divisor_tvalid}), 66'd0);
        chk("rst_div_cycles", 66'(div_cycles), 66'd0);
        chk("rst_we", 66'({hi_we, lo_we}), 66'd0);
        step(); reset = 1'b0;

        // mult / multu, directed operands
        step(); es_valid = 1'b1; op_mult = 1'b1; src1 = 32'hFFFF_FFFE; src2 = 32'd3;
        push(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        sample(); chk("mult_ready_go", 66'(ready_go), 66'd1);
        step(); op_mult = 1'b0; op_multu = 1'b1;
        push(1'b1, 1'b1, 32'h0000_0002, 32'hFFFF_FFFA);
        sample(); chk("multu_ready_go", 66'(ready_go), 66'd1);

        // mult / multu, random operands against a longint model
        for (int i = 0; i < 4; i++) begin
            step(); op_multu = 1'b0; op_mult = 1'b1; src1 = $urandom; src2 = $urandom;
            sa = longint'($signed(src1)); sb = longint'($signed(src2)); sp = sa * sb;
            push(1'b1, 1'b1, sp[63:32], sp[31:0]);
            step(); op_mult = 1'b0; op_multu = 1'b1;
            ua = {32'h0, src1}; ub = {32'h0, src2}; up = ua * ub;
            push(1'b1, 1'b1, up[63:32], up[31:0]);
        end

        // Invalid EXE slot: no write
        step(); es_valid = 1'b0;
        sample(); chk("noval_we", 66'({hi_we, lo_we}), 66'd0);

        // mtlo
        step(); es_valid = 1'b1; op_multu = 1'b0; op_mtlo = 1'b1; src1 = 32'hCAFE_F00D;
        push(1'b0, 1'b1, 32'h0, 32'hCAFE_F00D);
        sample();

        // mthi stalled by MEM, then released
        step(); op_mtlo = 1'b0; op_mthi = 1'b1; src1 = 32'h1234_5678; ms_allowin = 1'b0;
        push(1'b1, 1'b0, 32'h1234_5678, 32'h0);
        sample(); chk("mthi_stall_we0", 66'({hi_we, lo_we}), 66'd0);
        chk("mthi_stall_ready_go", 66'(ready_go), 66'd1);
        step(); sample(); chk("mthi_stall_we1", 66'({hi_we, lo_we}), 66'd0);
        step(); ms_allowin = 1'b1;
        sample();
        step(); es_valid = 1'b0; op_mthi = 1'b0;

        // div 7 / -2 on the signed IP, result after ~20 cycles
        sdiv_dividend_tready = 1'b1; sdiv_divisor_tready = 1'b1;
        step(); es_valid = 1'b1; op_div = 1'b1; src1 = 32'd7; src2 = 32'hFFFF_FFFE;
        push(1'b1, 1'b1, 32'h0000_0001, 32'hFFFF_FFFD);
        sample(); chk("div_idle_ready_go", 66'(ready_go), 66'd0);
        chk("div_idle_tvalids", 66'({sdiv_dividend_tvalid, sdiv_divisor_tvalid}), 66'd0);
        chk("div_operands", 66'({div_dividend_tdata, div_divisor_tdata}),
            66'({32'd7, 32'hFFFF_FFFE}));
        step();
        sample(); chk("div_send_tvalids", 66'({sdiv_dividend_tvalid, sdiv_divisor_tvalid,
                                             udiv_dividend_tvalid, udiv_divisor_tvalid}),
                      66'b1100);
        chk("div_send_busy", 66'(busy), 66'd1);
        chk("div_send_cycles", 66'(div_cycles), 66'd0);
        step();
        sample(); chk("div_wait_tvalids", 66'({sdiv_dividend_tvalid, sdiv_divisor_tvalid}),
                      66'd0);
        for (int i = 0; i < 19; i++) begin
            step(); sample(); chk("div_wait_ready_go", 66'(ready_go), 66'd0);
        end
        sdiv_dout_tvalid = 1'b1; sdiv_dout_tdata = {32'hFFFF_FFFD, 32'h0000_0001};
        step(); sdiv_dout_tvalid = 1'b0;
        sample(); chk("div_done_ready_go", 66'(ready_go), 66'd1);
        chk("div_cycles_21", 66'(div_cycles), 66'd21);
        step(); es_valid = 1'b0; op_div = 1'b0;
        sample(); chk("div_idle_busy", 66'(busy), 66'd0);
        chk("div_cycles_hold", 66'(div_cycles), 66'd21);

        // divu: dividend tready late, divisor immediate; stray douts ignored
        udiv_divisor_tready = 1'b1; udiv_dividend_tready = 1'b0;
        step(); es_valid = 1'b1; op_divu = 1'b1; src1 = 32'd100; src2 = 32'd7;
        push(1'b1, 1'b1, 32'd2, 32'd14);
        sample(); chk("divu_t0", 66'({udiv_dividend_tvalid, udiv_divisor_tvalid}), 66'b00);
        step();
        sample(); chk("divu_t1", 66'({udiv_dividend_tvalid, udiv_divisor_tvalid}), 66'b11);
        chk("divu_no_sdiv", 66'({sdiv_dividend_tvalid, sdiv_divisor_tvalid}), 66'b00);
        step();
        sample(); chk("divu_t2", 66'({udiv_dividend_tvalid, udiv_divisor_tvalid}), 66'b10);
        step();
        sample(); chk("divu_t3", 66'({udiv_dividend_tvalid, udiv_divisor_tvalid}), 66'b10);
        udiv_dout_tvalid = 1'b1; udiv_dout_tdata = 64'hDEAD_BEEF_0BAD_F00D;
        step(); udiv_dout_tvalid = 1'b0; udiv_dividend_tready = 1'b1;
        sample(); chk("divu_t4", 66'({udiv_dividend_tvalid, udiv_divisor_tvalid}), 66'b10);
        chk("divu_send_ready_go", 66'(ready_go), 66'd0);
        step(); udiv_dividend_tready = 1'b0;
        sample(); chk("divu_t5", 66'({udiv_dividend_tvalid, udiv_divisor_tvalid}), 66'b00);
        chk("divu_wait_busy", 66'(busy), 66'd1);
        sdiv_dout_tvalid = 1'b1; sdiv_dout_tdata = 64'h1111_2222_3333_4444;
        step(); sdiv_dout_tvalid = 1'b0;
        sample(); chk("divu_wait_ready_go", 66'(ready_go), 66'd0);
        udiv_dout_tvalid = 1'b1; udiv_dout_tdata = {32'd14, 32'd2};
        step(); udiv_dout_tvalid = 1'b0;
        sample(); chk("divu_done_ready_go", 66'(ready_go), 66'd1);
        chk("divu_cycles", 66'(div_cycles), 66'd6);
        step(); es_valid = 1'b0; op_divu = 1'b0;

        // div -9 / 4 held in DONE by MEM backpressure
        step(); es_valid = 1'b1; op_div = 1'b1; src1 = 32'hFFFF_FFF7; src2 = 32'd4;
        ms_allowin = 1'b0;
        push(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        step();
        step();
        sdiv_dout_tvalid = 1'b1; sdiv_dout_tdata = {32'hFFFF_FFFE, 32'hFFFF_FFFF};
        step(); sdiv_dout_tvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample();
            chk("stall_we", 66'({hi_we, lo_we}), 66'd0);
            chk("stall_ready_go", 66'(ready_go), 66'd1);
            chk("stall_tvalids", 66'({sdiv_dividend_tvalid, sdiv_divisor_tvalid}), 66'd0);
            step();
        end
        ms_allowin = 1'b1;
        sample(); chk("stall_release_ready_go", 66'(ready_go), 66'd1);
        step(); es_valid = 1'b0; op_div = 1'b0;
        sample(); chk("stall_idle_busy", 66'(busy), 66'd0);
        chk("stall_cycles", 66'(div_cycles), 66'd2);
        chk("stall_no_reissue", 66'({sdiv_dividend_tvalid, sdiv_divisor_tvalid}), 66'd0);

        // Reset in WAIT, then a late unsigned result
        udiv_dividend_tready = 1'b1; udiv_divisor_tready = 1'b1;
        step(); es_valid = 1'b1; op_divu = 1'b1; src1 = 32'd50; src2 = 32'd5;
        step();
        step();
        sample(); chk("rstw_busy_before", 66'(busy), 66'd1);
        step(); reset = 1'b1; es_valid = 1'b0; op_divu = 1'b0;
        sample(); chk("rstw_busy", 66'(busy), 66'd0);
        chk("rstw_cycles", 66'(div_cycles), 66'd0);
        chk("rstw_tvalids", 66'({udiv_dividend_tvalid, udiv_divisor_tvalid}), 66'd0);
        step(); reset = 1'b0;
        udiv_dout_tvalid = 1'b1; udiv_dout_tdata = {32'd10, 32'd0};
        step(); udiv_dout_tvalid = 1'b0;
        sample(); chk("rstw_late_busy", 66'(busy), 66'd0);
        chk("rstw_late_cycles", 66'(div_cycles), 66'd0);
        step();

        sample(); chk("sb_drained", 66'(sb_q.size()), 66'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
